// File: rtl/ctrl_seq_pkg.sv
// Shared types for the sequential accumulator-ISA control unit:
// opcode mnemonics, FSM states and the raw decode bundle.
package ctrl_seq_pkg;

  localparam int unsigned OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    LW, SW, ADD, SUB, AND, OR, SL, SR,
    BEQ, BGE, BNE, MOV, ASSIGN, CLRSC, JMP, DONE
  } op_mne;

  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, HALT} ctrl_st_t;

  // Accumulator lives at the top of the register file; sliced to RAW bits by users.
  localparam logic [15:0] ACC_ADDR = '1;

  typedef struct packed {
    logic jump;
    logic sc_en;
    logic sc_clr;
    logic reg_exe;
    logic imm_exe;
    logic mem_rd;
    logic mem_wr;
    logic reg_to_acc;
    logic acc_to_reg;
    logic assign_val;
    logic reg_wr_en;
    logic is_done;
  } dec_t;

endpackage

// File: rtl/ctrl_seq_dec.sv
// Purely combinational opcode/mode decode into ungated strobes,
// raw register-write enable and write address.
module ctrl_dec
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned IW  = 9,
  parameter int unsigned OPW = 4,
  parameter int unsigned RAW = 4
) (
  input  logic [IW-1:0]  Instruction,
  output dec_t           dec,
  output logic [RAW-1:0] wr_addr
);

  logic [OPW-1:0] opc;
  logic           mode;
  logic [RAW-1:0] opnd;
  logic           known;
  op_mne          op;

  assign opc  = Instruction[IW-1 -: OPW];
  assign mode = Instruction[IW-OPW-1];
  assign opnd = Instruction[RAW-1:0];
  // Opcodes beyond the 16 mnemonics fall through as an accumulator-writing NOP.
  assign known = ((opc >> OPC_W) == '0);
  assign op    = op_mne'(opc[OPC_W-1:0]);

  always_comb begin
    logic alu;
    alu           = 1'b0;
    dec           = '0;
    dec.reg_wr_en = 1'b1;
    wr_addr       = ACC_ADDR[RAW-1:0];
    if (known) begin
      case (op)
        LW:          begin dec.mem_rd = 1'b1; wr_addr = opnd; end
        SW:          begin dec.mem_wr = 1'b1; dec.reg_wr_en = 1'b0; end
        ADD, SUB:    begin dec.sc_en = 1'b1; alu = 1'b1; end
        AND, OR:     alu = 1'b1;
        SL, SR:      begin dec.sc_en = 1'b1; wr_addr = opnd; end
        BEQ, BGE, BNE: begin alu = 1'b1; dec.reg_wr_en = 1'b0; end
        MOV: begin
          if (mode) begin
            dec.acc_to_reg = 1'b1;
            wr_addr        = opnd;
          end else begin
            dec.reg_to_acc = 1'b1;
          end
        end
        ASSIGN:      dec.assign_val = 1'b1;
        CLRSC:       begin dec.sc_clr = 1'b1; dec.reg_wr_en = 1'b0; end
        JMP:         begin dec.jump = 1'b1; dec.reg_wr_en = 1'b0; end
        DONE:        begin dec.is_done = 1'b1; dec.reg_wr_en = 1'b0; end
        default:     ;
      endcase
    end
    dec.reg_exe = alu & ~mode;
    dec.imm_exe = alu & mode;
  end

endmodule

// File: rtl/ctrl_seq.sv
// Run/halt sequencer around ctrl_dec: gates strobes by state, stretches
// LW/SW over MEM_LAT cycles and keeps a saturating cycle counter.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned IW      = 9,
  parameter int unsigned OPW     = 4,
  parameter int unsigned RAW     = 4,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CW      = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [IW-1:0]  Instruction,
  output logic           pc_en,
  output logic           jump_en,
  output logic           sc_en,
  output logic           sc_clr,
  output logic           reg_exe,
  output logic           imm_exe,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           reg_to_acc,
  output logic           acc_to_reg,
  output logic           assign_val,
  output logic           reg_wr_en,
  output logic [RAW-1:0] reg_wr_addr,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  cycle_ct
);

  dec_t           dec;
  logic [RAW-1:0] dec_addr;

  ctrl_dec #(.IW(IW), .OPW(OPW), .RAW(RAW)) u_dec (
    .Instruction(Instruction),
    .dec        (dec),
    .wr_addr    (dec_addr)
  );

  ctrl_st_t      st_q;
  logic [3:0]    wait_ct_q;
  logic [CW-1:0] cycle_ct_q, cycle_ct_d;

  logic in_run, active, multi, last, commit;

  assign in_run = (st_q == RUN);
  assign busy   = in_run || (st_q == MEM_WAIT);
  // Reset masks strobes in its own cycle so an aborted access never writes.
  assign active = busy && !Reset;
  assign multi  = (MEM_LAT > 1) && (dec.mem_rd || dec.mem_wr);
  assign last   = (st_q == MEM_WAIT) && (wait_ct_q == 4'd1);
  assign commit = in_run ? !multi : last;

  assign pc_en       = active && (in_run ? !(multi || dec.is_done) : last);
  assign jump_en     = active && dec.jump;
  assign sc_en       = active && dec.sc_en;
  assign sc_clr      = active && dec.sc_clr;
  assign reg_exe     = active && dec.reg_exe;
  assign imm_exe     = active && dec.imm_exe;
  assign mem_rd      = active && dec.mem_rd;
  assign mem_wr      = active && dec.mem_wr && commit;
  assign reg_to_acc  = active && dec.reg_to_acc;
  assign acc_to_reg  = active && dec.acc_to_reg;
  assign assign_val  = active && dec.assign_val;
  assign reg_wr_en   = active && dec.reg_wr_en && commit;
  assign reg_wr_addr = active ? dec_addr : ACC_ADDR[RAW-1:0];
  assign done        = (st_q == HALT) || (active && in_run && dec.is_done);
  assign cycle_ct    = cycle_ct_q;

  assign cycle_ct_d = (cycle_ct_q == '1) ? cycle_ct_q : cycle_ct_q + 1'b1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st_q       <= IDLE;
      wait_ct_q  <= '0;
      cycle_ct_q <= '0;
    end else begin
      case (st_q)
        IDLE, HALT: begin
          if (Start) begin
            st_q       <= RUN;
            cycle_ct_q <= '0;
          end
        end
        RUN: begin
          cycle_ct_q <= cycle_ct_d;
          if (dec.is_done) begin
            st_q <= HALT;
          end else if (multi) begin
            st_q      <= MEM_WAIT;
            wait_ct_q <= 4'(MEM_LAT - 1);
          end
        end
        MEM_WAIT: begin
          cycle_ct_q <= cycle_ct_d;
          wait_ct_q  <= wait_ct_q - 4'd1;
          if (wait_ct_q == 4'd1) st_q <= RUN;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: a MEM_LAT=3/CW=16 instance and a
// MEM_LAT=1/CW=4 instance share stimulus; each scenario checks one of them.
module tb_ctrl_seq;

  localparam logic [3:0] O_LW = 4'd0, O_SW = 4'd1, O_ADD = 4'd2, O_AND = 4'd4,
                         O_SL = 4'd6, O_BGE = 4'd9, O_BNE = 4'd10, O_MOV = 4'd11,
                         O_ASG = 4'd12, O_CLR = 4'd13, O_JMP = 4'd14, O_DONE = 4'd15;

  localparam logic [13:0] M_PC  = 14'h2000, M_JMP = 14'h1000, M_SC  = 14'h0800,
                          M_CLR = 14'h0400, M_REX = 14'h0200, M_IMX = 14'h0100,
                          M_MRD = 14'h0080, M_MWR = 14'h0040, M_R2A = 14'h0020,
                          M_A2R = 14'h0010, M_ASG = 14'h0008, M_WEN = 14'h0004,
                          M_BSY = 14'h0002, M_DN  = 14'h0001;

  typedef struct {
    string       name;
    logic [33:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [8:0] Instruction = '0;

  always #5 Clk = ~Clk;

  logic        m_pc, m_jmp, m_sc, m_clr, m_rex, m_imx, m_mrd, m_mwr, m_r2a, m_a2r, m_asg, m_wen, m_bsy, m_dn;
  logic [3:0]  m_addr;
  logic [15:0] m_cyc;
  logic        d_pc, d_jmp, d_sc, d_clr, d_rex, d_imx, d_mrd, d_mwr, d_r2a, d_a2r, d_asg, d_wen, d_bsy, d_dn;
  logic [3:0]  d_addr;
  logic [3:0]  d_cyc;

  ctrl_seq #(.IW(9), .OPW(4), .RAW(4), .MEM_LAT(3), .CW(16)) u_m (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .pc_en(m_pc), .jump_en(m_jmp), .sc_en(m_sc), .sc_clr(m_clr), .reg_exe(m_rex),
    .imm_exe(m_imx), .mem_rd(m_mrd), .mem_wr(m_mwr), .reg_to_acc(m_r2a),
    .acc_to_reg(m_a2r), .assign_val(m_asg), .reg_wr_en(m_wen), .reg_wr_addr(m_addr),
    .busy(m_bsy), .done(m_dn), .cycle_ct(m_cyc)
  );

  ctrl_seq #(.IW(9), .OPW(4), .RAW(4), .MEM_LAT(1), .CW(4)) u_d (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .pc_en(d_pc), .jump_en(d_jmp), .sc_en(d_sc), .sc_clr(d_clr), .reg_exe(d_rex),
    .imm_exe(d_imx), .mem_rd(d_mrd), .mem_wr(d_mwr), .reg_to_acc(d_r2a),
    .acc_to_reg(d_a2r), .assign_val(d_asg), .reg_wr_en(d_wen), .reg_wr_addr(d_addr),
    .busy(d_bsy), .done(d_dn), .cycle_ct(d_cyc)
  );

  logic [33:0] obs_m, obs_d;
  assign obs_m = {m_pc, m_jmp, m_sc, m_clr, m_rex, m_imx, m_mrd, m_mwr, m_r2a, m_a2r,
                  m_asg, m_wen, m_bsy, m_dn, m_addr, m_cyc};
  assign obs_d = {d_pc, d_jmp, d_sc, d_clr, d_rex, d_imx, d_mrd, d_mwr, d_r2a, d_a2r,
                  d_asg, d_wen, d_bsy, d_dn, d_addr, 12'h000, d_cyc};

  function automatic logic [8:0] ins(logic [3:0] op, logic mode, logic [3:0] r);
    return {op, mode, r};
  endfunction

  function automatic logic [33:0] mk(logic [13:0] s, logic [3:0] a, logic [15:0] c);
    return {s, a, c};
  endfunction

  // Leaves both instances in RUN with cycle_ct=0 at the following drive point.
  task automatic start_prog();
    Reset = 1'b1; Start = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    Reset = 1'b1; Start = 1'b1; Instruction = ins(O_ADD, 1'b1, 4'd3);
    @(posedge Clk); #1;
    sb.push_back('{"rst_hold", mk(14'h0, 4'hF, 16'd0)});
    @(negedge Clk);
    e = sb.pop_front(); n_chk++;
    if (obs_m !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs_m, e.v); end
    @(posedge Clk); #1;
    Reset = 1'b0; Start = 1'b0;
    sb.push_back('{"rst_prio_m", mk(14'h0, 4'hF, 16'd0)});
    sb.push_back('{"rst_prio_d", mk(14'h0, 4'hF, 16'd0)});
    @(negedge Clk);
    e = sb.pop_front(); n_chk++;
    if (obs_m !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs_m, e.v); end
    e = sb.pop_front(); n_chk++;
    if (obs_d !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs_d, e.v); end
    @(posedge Clk); #1;
  endtask

  task automatic test_add_imm();
    exp_t e;
    start_prog();
    for (int i = 0; i < 2; i++) begin
      Instruction = ins(O_ADD, 1'b1, 4'd3);
      sb.push_back('{$sformatf("add_imm%0d", i), mk(M_PC | M_IMX | M_SC | M_WEN | M_BSY, 4'hF, 16'(i))});
      @(negedge Clk);
      e = sb.pop_front(); n_chk++;
      if (obs_m !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs_m, e.v); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    exp_t e;
    logic [8:0]  prog [4];
    logic [33:0] ex   [4];
    prog = '{ins(O_LW, 1'b0, 4'd5), ins(O_LW, 1'b0, 4'd5), ins(O_LW, 1'b0, 4'd5), ins(O_ADD, 1'b0, 4'd1)};
    ex   = '{mk(M_MRD | M_BSY, 4'd5, 16'd0),
             mk(M_MRD | M_BSY, 4'd5, 16'd1),
             mk(M_PC | M_MRD | M_WEN | M_BSY, 4'd5, 16'd2),
             mk(M_PC | M_REX | M_SC | M_WEN | M_BSY, 4'hF, 16'd3)};
    start_prog();
    for (int i = 0; i < 4; i++) begin
      Instruction = prog[i];
      sb.push_back('{$sformatf("lw_wait%0d", i), ex[i]});
      @(negedge Clk);
      e = sb.pop_front(); n_chk++;
      if (obs_m !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs_m, e.v); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_sw_abort();
    exp_t e;
    logic        rst [7];
    logic [33:0] ex  [7];
    rst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ex  = '{mk(M_BSY, 4'hF, 16'd0), mk(M_BSY, 4'hF, 16'd1),
            mk(M_PC | M_MWR | M_BSY, 4'hF, 16'd2),
            mk(M_BSY, 4'hF, 16'd3), mk(M_BSY, 4'hF, 16'd4),
            mk(14'h0, 4'hF, 16'd0), mk(14'h0, 4'hF, 16'd0)};
    start_prog();
    for (int i = 0; i < 7; i++) begin
      Instruction = ins(O_SW, 1'b0, 4'd2);
      Reset = rst[i];
      sb.push_back('{$sformatf("sw_abort%0d", i), ex[i]});
      @(negedge Clk);
      e = sb.pop_front(); n_chk++;
      if (obs_m !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs_m, e.v); end
      @(posedge Clk); #1;
    end
    Reset = 1'b0;
  endtask

  task automatic test_mov_branch();
    exp_t e;
    logic [8:0]  prog [7];
    logic [33:0] ex   [7];
    prog = '{ins(O_MOV, 1'b1, 4'd9), ins(O_BNE, 1'b0, 4'd3), ins(O_SL, 1'b0, 4'd4),
             ins(O_ASG, 1'b1, 4'd7), ins(O_CLR, 1'b0, 4'd0), ins(O_MOV, 1'b0, 4'd2),
             ins(O_BGE, 1'b1, 4'd1)};
    ex   = '{mk(M_PC | M_A2R | M_WEN | M_BSY, 4'd9, 16'd0),
             mk(M_PC | M_REX | M_BSY, 4'hF, 16'd1),
             mk(M_PC | M_SC | M_WEN | M_BSY, 4'd4, 16'd2),
             mk(M_PC | M_ASG | M_WEN | M_BSY, 4'hF, 16'd3),
             mk(M_PC | M_CLR | M_BSY, 4'hF, 16'd4),
             mk(M_PC | M_R2A | M_WEN | M_BSY, 4'hF, 16'd5),
             mk(M_PC | M_IMX | M_BSY, 4'hF, 16'd6)};
    start_prog();
    for (int i = 0; i < 7; i++) begin
      Instruction = prog[i];
      sb.push_back('{$sformatf("mov_br%0d", i), ex[i]});
      @(negedge Clk);
      e = sb.pop_front(); n_chk++;
      if (obs_m !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs_m, e.v); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_done_halt();
    exp_t e;
    logic [33:0] run_ex;
    start_prog();
    for (int i = 0; i < 21; i++) begin
      Start = (i == 18);
      Instruction = (i == 7) ? ins(O_DONE, 1'b0, 4'd0) : ins(O_ADD, 1'b1, 4'd1);
      run_ex = M_PC | M_IMX | M_SC | M_WEN | M_BSY;
      if (i < 7)       sb.push_back('{$sformatf("halt%0d", i), mk(run_ex, 4'hF, 16'(i))});
      else if (i == 7) sb.push_back('{"halt_done", mk(M_DN | M_BSY, 4'hF, 16'd7)});
      else if (i < 19) sb.push_back('{$sformatf("halt_frz%0d", i), mk(M_DN, 4'hF, 16'd8)});
      else             sb.push_back('{$sformatf("halt_rst%0d", i), mk(run_ex, 4'hF, 16'(i - 19))});
      @(negedge Clk);
      e = sb.pop_front(); n_chk++;
      if (obs_m !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs_m, e.v); end
      @(posedge Clk); #1;
    end
    Start = 1'b0;
  endtask

  task automatic test_saturate();
    exp_t e;
    logic [8:0]  pat [5];
    logic [13:0] pex [5];
    logic [3:0]  pad [5];
    pat = '{ins(O_ADD, 1'b1, 4'd3), ins(O_LW, 1'b0, 4'd6), ins(O_SW, 1'b0, 4'd2),
            ins(O_JMP, 1'b0, 4'd0), ins(O_AND, 1'b0, 4'd1)};
    pex = '{M_PC | M_IMX | M_SC | M_WEN | M_BSY, M_PC | M_MRD | M_WEN | M_BSY,
            M_PC | M_MWR | M_BSY, M_PC | M_JMP | M_BSY, M_PC | M_REX | M_WEN | M_BSY};
    pad = '{4'hF, 4'd6, 4'hF, 4'hF, 4'hF};
    start_prog();
    for (int i = 0; i < 23; i++) begin
      Start = (i == 10);
      if (i < 20) begin
        Instruction = pat[i % 5];
        sb.push_back('{$sformatf("sat%0d", i), mk(pex[i % 5], pad[i % 5], (i < 15) ? 16'(i) : 16'd15)});
      end else begin
        Instruction = ins(O_DONE, 1'b0, 4'd0);
        sb.push_back('{$sformatf("sat_end%0d", i), mk((i == 20) ? (M_DN | M_BSY) : M_DN, 4'hF, 16'd15)});
      end
      @(negedge Clk);
      e = sb.pop_front(); n_chk++;
      if (obs_d !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs_d, e.v); end
      @(posedge Clk); #1;
    end
    Start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_lw_wait();
    test_sw_abort();
    test_mov_branch();
    test_done_halt();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
Sequential, parametrised successor to the single-cycle control decoder for the accumulator ISA. It decodes the instruction and gates every strobe with a run/halt FSM. It stretches LW/SW over a configurable memory latency and stalls the fetch unit through an explicit pc_en. It also keeps a saturating cycle counter for benchmarking. It sits between instrROM/program_counter and the datapath (regfile, ALU, data memory).

Parameters:
IW, 9, instruction width
OPW, 4, opcode width; opcode = Instruction[IW-1 -: OPW]; mode bit = Instruction[IW-OPW-1]
RAW, 4, register address width; operand = Instruction[RAW-1:0]
MEM_LAT, 1, data-memory access cycles for LW/SW (legal range 1..15)
CW, 16, cycle counter width

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high reset
Start  in  1  begin/restart program; one-cycle pulse
Instruction  in  IW  machine code from instrROM
pc_en  out  1  fetch unit may advance (PC+1, or target when jump_en)
jump_en  out  1  JMP
sc_en  out  1  carry register load (ADD, SUB, SL, SR)
sc_clr  out  1  CLRSC
reg_exe  out  1  ALU op with register operand (mode=0)
imm_exe  out  1  ALU op with immediate operand (mode=1)
mem_rd  out  1  data-memory read (LW)
mem_wr  out  1  data-memory write (SW)
reg_to_acc  out  1  MOV, mode=0
acc_to_reg  out  1  MOV, mode=1
assign_val  out  1  ASSIGN
reg_wr_en  out  1  regfile write
reg_wr_addr  out  RAW  regfile write address
busy  out  1  state is RUN or MEM_WAIT
done  out  1  program finished; sticky
cycle_ct  out  CW  executed cycles since Start

Behaviour:
- Clocking and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: state=IDLE, wait_ct=0, cycle_ct=0, done=0. All strobes=0, reg_wr_addr = all ones.
- States: IDLE, RUN, MEM_WAIT, HALT.
- All decode strobes, pc_en and reg_wr_en are 0 unless state is RUN or MEM_WAIT.
- IDLE:
  - Start=1 -> RUN next cycle.
  - cycle_ct cleared to 0 in the same edge.
- RUN, per-instruction decode (combinational from Instruction):
  - ALU-class ops (ADD, SUB, AND, OR, BEQ, BGE, BNE): reg_exe when mode=0, imm_exe when mode=1.
  - reg_wr_en=1 except for BEQ, BGE, BNE, CLRSC, SW, JMP, DONE.
  - reg_wr_addr = Instruction[RAW-1:0] for LW, SL, SR and MOV with mode=1; otherwise all ones (accumulator).
- RUN, non-memory opcodes and LW/SW with MEM_LAT=1: single cycle, pc_en=1, state stays RUN.
- RUN, LW/SW with MEM_LAT>1:
  - First cycle: pc_en=0, wait_ct <= MEM_LAT-1, next state MEM_WAIT.
- MEM_WAIT:
  - Instruction is guaranteed stable because the PC is held. Decode is held.
  - wait_ct decrements each cycle. The cycle with wait_ct==1 is the final cycle; it asserts pc_en and returns to RUN.
- Memory strobes during a multi-cycle access:
  - LW: mem_rd high for all MEM_LAT cycles. reg_wr_en high only in the final cycle.
  - SW: mem_wr high only in the final cycle, so exactly one write.
- DONE opcode in RUN:
  - done is asserted combinationally in that cycle; pc_en=0; next state HALT.
- HALT:
  - done held 1; all other strobes 0; cycle_ct frozen.
  - Start=1 -> RUN and done deasserts next cycle. cycle_ct restarts from 0.
- Start while in RUN or MEM_WAIT is ignored.
- cycle_ct:
  - Increments by 1 every cycle in RUN or MEM_WAIT, including the DONE cycle.
  - Saturates at 2^CW-1; never wraps.
- Reset asserted in MEM_WAIT aborts the access: no mem_wr pulse and no reg_wr_en in that cycle or after.
- Reset has priority over Start in the same cycle.
- Undefined opcodes: treated as NOP with reg_wr_en=1 to the accumulator, matching the existing single-cycle decode; pc_en=1.

Decomposition:
- Package definitions:
  - op_mne opcode enum (LW, SW, ADD, SUB, AND, OR, SL, SR, BEQ, BGE, BNE, MOV, ASSIGN, CLRSC, JMP, DONE) at OPW bits.
  - New ctrl_st_t enum {IDLE, RUN, MEM_WAIT, HALT}.
  - Localparam ACC_ADDR = all ones.
- Sub-module ctrl_dec: purely combinational opcode/mode -> raw strobes, raw reg_wr_en and reg_wr_addr.
- ctrl_seq owns the FSM, wait_ct, cycle_ct and the gating of the ctrl_dec outputs.

Test Plan:
1. Reset, then Start pulse, then ADD mode=1 -> next cycle: imm_exe=1, sc_en=1, reg_wr_en=1, reg_wr_addr=4'hF, pc_en=1, busy=1, cycle_ct=0 then 1.
2. MEM_LAT=3, LW r5 -> mem_rd=1 for 3 cycles; pc_en=0,0,1; reg_wr_en=0,0,1; reg_wr_addr=5; state returns to RUN.
3. MEM_LAT=3, SW -> mem_wr=0,0,1; reg_wr_en=0 throughout; Reset pulsed in the 2nd cycle of a second SW -> no mem_wr; state=IDLE, cycle_ct=0.
4. MOV mode=1 r9, then BNE mode=0 -> acc_to_reg=1, reg_wr_addr=9; then reg_exe=1, reg_wr_en=0.
5. DONE after 7 RUN cycles -> done=1, state HALT; cycle_ct=8 and stays frozen for 10 idle cycles; Start -> done=0, cycle_ct restarts.
6. CW=4, a 20-instruction loop -> cycle_ct saturates at 15; Start asserted mid-run is ignored; JMP cycle shows jump_en=1, pc_en=1, reg_wr_en=0.
